scaled_frame_loader: RTL and testbench

Parametrised frame source that streams a stored image from an external synchronous ROM into an internal FIFO. It applies independent integer horizontal and vertical upscaling, selectable per frame, and feeds the display/filter pipeline through a `next`/`valid` pull interface. Frame restart is driven by the active-low vertical sync from the video timing generator. In-flight ROM reads are credit-tracked, so the FIFO can never overflow regardless of `ROM_LAT`.

---
 rtl/scaled_frame_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_scaled_frame_loader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaled_frame_loader.sv
// scaled_frame_loader
//   Streams a stored image out of an external synchronous ROM into an
//   internal FIFO. Each pixel can be repeated horizontally (hs times on the
//   output) and each row vertically (vs fetch passes). Both factors are chosen
//   per frame. Downstream logic pulls pixels through a next/valid interface.
//   ROM reads still in flight are counted against the FIFO space, so the FIFO
//   cannot overflow whatever the ROM latency is.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   i_vsync           active-low frame restart (synchronous)
//   i_hscale/i_vscale repeat factors, latched while i_vsync is low (0 means 1)
//   o_rom_ce          ROM read strobe (registered)
//   o_rom_addr        ROM read address (registered)
//   i_rom_data        ROM data, ROM_LAT cycles after the read strobe
//   i_next            consumer takes one output pixel
//   o_data/o_valid    current output pixel and its valid flag
//   o_frame_done      pulses in the cycle the last read of a frame is issued
//   o_underrun        sticky: i_next seen while o_valid was low
module scaled_frame_loader #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int IMG_W      = 225,
  parameter int IMG_H      = 225,
  parameter int START_ADDR = 12,
  parameter int FIFO_AW    = 8,
  parameter int ROM_LAT    = 2,
  parameter int SCALE_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vsync,
  input  logic [SCALE_W-1:0] i_hscale,
  input  logic [SCALE_W-1:0] i_vscale,
  output logic              o_rom_ce,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  input  logic              i_next,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_frame_done,
  output logic              o_underrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CNT_W = FIFO_AW + 1;
  localparam int INF_W = $clog2(ROM_LAT + 2);

  localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);

  logic [SCALE_W-1:0] hs_q, hs_d, vs_q, vs_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [SCALE_W-1:0] rep_q, rep_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ce_q, ce_d;
  logic [ROM_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCALE_W-1:0] hcnt_q, hcnt_d;
  logic               under_q, under_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [INF_W-1:0]   inflight;
  logic               credit_ok;
  logic               last_col, last_rep, last_row;
  logic               wr_en, accept, pop;

  // Reads not yet landed in the FIFO: the one on the ROM pins this cycle
  // plus everything in the return shift register. Adding them to the FIFO
  // fill level gives the total space already promised.
  always_comb begin
    inflight = INF_W'(ce_q);
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + INF_W'(vld_sr_q[i]);
    end
  end

  assign credit_ok = (int'(cnt_q) + int'(inflight)) < DEPTH;

  assign last_col = (col_q == COL_LAST);
  assign last_rep = (rep_q == vs_q - SCALE_W'(1));
  assign last_row = (row_q == ROW_LAST);

  // Data returning during a frame restart belongs to the old frame.
  assign wr_en  = vld_sr_q[ROM_LAT-1] & i_vsync;
  assign o_valid = (cnt_q != '0);
  assign accept = i_next & o_valid;
  assign pop    = accept & (hcnt_q == hs_q - SCALE_W'(1));

  assign o_rom_ce     = ce_q;
  assign o_rom_addr   = addr_q;
  assign o_data       = mem[rd_ptr_q];
  assign o_underrun   = under_q;
  assign o_frame_done = ce_q & i_vsync & last_col & last_rep & last_row;

  always_comb begin
    hs_d       = hs_q;
    vs_d       = vs_q;
    col_d      = col_q;
    row_d      = row_q;
    rep_d      = rep_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    ce_d       = ce_q;
    vld_sr_d   = vld_sr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    under_d    = under_q;

    if (!i_vsync) begin
      // Frame restart wins over everything else in the cycle.
      hs_d       = (i_hscale == '0) ? SCALE_W'(1) : i_hscale;
      vs_d       = (i_vscale == '0) ? SCALE_W'(1) : i_vscale;
      col_d      = '0;
      row_d      = '0;
      rep_d      = '0;
      row_base_d = START;
      addr_d     = START;
      ce_d       = 1'b0;
      vld_sr_d   = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      hcnt_d     = '0;
      under_d    = 1'b0;
    end else begin
      ce_d     = credit_ok;
      vld_sr_d = ROM_LAT'({vld_sr_q, ce_q});

      // addr_q always holds the address of the next read to issue, so it
      // only advances when the current one actually went out.
      if (ce_q) begin
        if (!last_col) begin
          addr_d = addr_q + ADDR_W'(1);
          col_d  = col_q + COL_W'(1);
        end else if (!last_rep) begin
          addr_d = row_base_q;
          rep_d  = rep_q + SCALE_W'(1);
          col_d  = '0;
        end else if (!last_row) begin
          addr_d     = row_base_q + ROW_STEP;
          row_base_d = row_base_q + ROW_STEP;
          row_d      = row_q + ROW_W'(1);
          rep_d      = '0;
          col_d      = '0;
        end else begin
          addr_d     = START;
          row_base_d = START;
          row_d      = '0;
          rep_d      = '0;
          col_d      = '0;
        end
      end

      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      end

      // Each FIFO word is shown hs times before it is really consumed.
      if (accept) begin
        hcnt_d = pop ? '0 : hcnt_q + SCALE_W'(1);
      end
      if (i_next && !o_valid) begin
        under_d = 1'b1;
      end

      case ({wr_en, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q       <= SCALE_W'(1);
      vs_q       <= SCALE_W'(1);
      col_q      <= '0;
      row_q      <= '0;
      rep_q      <= '0;
      row_base_q <= START;
      addr_q     <= START;
      ce_q       <= 1'b0;
      vld_sr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      under_q    <= 1'b0;
    end else begin
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rep_q      <= rep_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      ce_q       <= ce_d;
      vld_sr_q   <= vld_sr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      under_q    <= under_d;
    end
  end

  // Storage has no reset; o_data is only meaningful while o_valid is high.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= i_rom_data;
    end
  end

endmodule

// File: tb/tb_scaled_frame_loader.sv
// tb_scaled_frame_loader
//   Drives scaled_frame_loader with a small 4x2 image and a behavioural ROM.
//   A reference model tracks, per frame, the read order, the pixels queued
//   for output with the cycle they become visible, the horizontal repeat and
//   the credit in use; every cycle the DUT outputs are compared against it.
//   Directed sections pin the model with hand-worked literal expectations,
//   then a long randomized section exercises scales, stalls and restarts.
module tb_scaled_frame_loader;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 16;
  localparam int IMG_W      = 4;
  localparam int IMG_H      = 2;
  localparam int START_ADDR = 12;
  localparam int FIFO_AW    = 8;
  localparam int ROM_LAT    = 2;
  localparam int SCALE_W    = 3;
  localparam int DEPTH      = 1 << FIFO_AW;

  logic              clk;
  logic              rst_n;
  logic              i_vsync;
  logic [SCALE_W-1:0] i_hscale;
  logic [SCALE_W-1:0] i_vscale;
  logic              o_rom_ce;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] i_rom_data;
  logic              i_next;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_frame_done;
  logic              o_underrun;

  int testsRun    = 0;
  int testsFailed = 0;

  scaled_frame_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .START_ADDR(START_ADDR), .FIFO_AW(FIFO_AW), .ROM_LAT(ROM_LAT),
    .SCALE_W(SCALE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_vsync(i_vsync),
    .i_hscale(i_hscale), .i_vscale(i_vscale),
    .o_rom_ce(o_rom_ce), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .i_next(i_next), .o_data(o_data), .o_valid(o_valid),
    .o_frame_done(o_frame_done), .o_underrun(o_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: odd multiplier keeps every address in a 256 window distinct.
  function automatic int romFn(input int a);
    return (a * 29 + 101) & 255;
  endfunction

  // Address of the idx-th read of a frame, from plain raster arithmetic.
  function automatic int modelAddr(input int idx, input int vs);
    int line;
    line = idx / IMG_W;
    return (START_ADDR + (line / vs) * IMG_W + (idx % IMG_W)) & 16'hFFFF;
  endfunction

  // Synchronous ROM with ROM_LAT cycles of latency; junk when not read.
  logic [DATA_W-1:0] romPipe [ROM_LAT];
  assign i_rom_data = romPipe[ROM_LAT-1];
  initial begin
    for (int i = 0; i < ROM_LAT; i++) romPipe[i] = '0;
    forever begin
      @(posedge clk);
      romPipe[0] <= o_rom_ce ? DATA_W'(romFn(int'(o_rom_addr))) : DATA_W'($urandom);
      for (int i = 1; i < ROM_LAT; i++) romPipe[i] <= romPipe[i-1];
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    int addr;
    int ready;
  } entry_t;

  entry_t mq[$];
  int  mIdx, mIssued, mPopped, mHcnt, mHs, mVs, cyc;
  bit  mCe, mUnder;

  task automatic modelReset();
    mq.delete();
    mIdx = 0; mIssued = 0; mPopped = 0; mHcnt = 0;
    mHs = 1; mVs = 1; mCe = 1'b0; mUnder = 1'b0;
  endtask

  // Compare this cycle's outputs, then advance the model with the inputs the
  // DUT will sample at the coming rising edge.
  task automatic modelStep();
    int  frameLen;
    int  arrived;
    bit  expValid;
    bit  nextCe;
    entry_t e;
    if (!rst_n) begin
      modelReset();
      return;
    end
    frameLen = IMG_W * IMG_H * mVs;
    expValid = (mq.size() > 0) && (mq[0].ready <= cyc);

    checkOutput("romCe", int'(o_rom_ce), int'(mCe));
    checkOutput("romAddr", int'(o_rom_addr), modelAddr(mIdx, mVs));
    checkOutput("frameDone", int'(o_frame_done),
                int'(mCe && i_vsync && (mIdx == frameLen - 1)));
    checkOutput("valid", int'(o_valid), int'(expValid));
    if (expValid) checkOutput("data", int'(o_data), romFn(mq[0].addr));
    checkOutput("underrun", int'(o_underrun), int'(mUnder));

    arrived = 0;
    foreach (mq[i]) if (mq[i].ready <= cyc) arrived++;
    if (arrived > DEPTH) checkOutput("fifoOverflow", arrived, DEPTH);

    if (!i_vsync) begin
      mHs = (i_hscale == 0) ? 1 : int'(i_hscale);
      mVs = (i_vscale == 0) ? 1 : int'(i_vscale);
      mq.delete();
      mIdx = 0; mIssued = 0; mPopped = 0; mHcnt = 0;
      mUnder = 1'b0; mCe = 1'b0;
    end else begin
      if (mCe) begin
        e.addr  = modelAddr(mIdx, mVs);
        e.ready = cyc + ROM_LAT + 1;
        mq.push_back(e);
        mIdx = (mIdx + 1) % frameLen;
        mIssued++;
      end
      nextCe = (mIssued - mPopped) < DEPTH;
      if (i_next) begin
        if (expValid) begin
          if (mHcnt == mHs - 1) begin
            mHcnt = 0;
            void'(mq.pop_front());
            mPopped++;
          end else begin
            mHcnt++;
          end
        end else begin
          mUnder = 1'b1;
        end
      end
      mCe = nextCe;
    end
    cyc++;
  endtask

  initial begin
    cyc = 0;
    modelReset();
    forever begin
      @(negedge clk);
      modelStep();
    end
  end

  // One cycle of inputs; returns at the falling edge of that cycle.
  task automatic applyStimulus(input logic vsIn, input logic nextIn,
                               input logic [SCALE_W-1:0] hIn,
                               input logic [SCALE_W-1:0] vIn);
    @(posedge clk);
    #1;
    i_vsync  = vsIn;
    i_next   = nextIn;
    i_hscale = hIn;
    i_vscale = vIn;
    @(negedge clk);
  endtask

  // Global time limit so the run can never hang.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int addrSeq[$];
  int dataSeq[$];
  int expAddr [17] = '{12, 13, 14, 15, 12, 13, 14, 15,
                       16, 17, 18, 19, 16, 17, 18, 19, 12};
  int doneAt;
  int ceCount;
  int run12, run13, k;
  bit waitOk;
  int pNext;
  logic [SCALE_W-1:0] curH, curV;

  initial begin
    rst_n = 1'b0; i_vsync = 1'b0; i_next = 1'b0;
    i_hscale = 3'd1; i_vscale = 3'd1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    checkOutput("rstCe", int'(o_rom_ce), 0);
    checkOutput("rstAddr", int'(o_rom_addr), 12);
    checkOutput("rstValid", int'(o_valid), 0);
    checkOutput("rstDone", int'(o_frame_done), 0);
    checkOutput("rstUnderrun", int'(o_underrun), 0);

    // First read and first-pixel latency
    applyStimulus(1'b0, 1'b0, 3'd1, 3'd1);
    applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
    checkOutput("firstCeLow", int'(o_rom_ce), 0);
    applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
    checkOutput("firstCe", int'(o_rom_ce), 1);
    checkOutput("firstAddr", int'(o_rom_addr), 12);
    applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
    checkOutput("latValid1", int'(o_valid), 0);
    applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
    checkOutput("latValid2", int'(o_valid), 0);
    applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
    checkOutput("latValid3", int'(o_valid), 1);
    checkOutput("firstData", int'(o_data), romFn(12));

    // Underrun before data arrives
    applyStimulus(1'b0, 1'b0, 3'd1, 3'd1);
    applyStimulus(1'b1, 1'b1, 3'd1, 3'd1);
    applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
    checkOutput("underrunSet", int'(o_underrun), 1);
    waitOk = 1'b0;
    for (int i = 0; i < 10 && !waitOk; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
      waitOk = o_valid;
    end
    checkOutput("underrunWaitValid", int'(waitOk), 1);
    checkOutput("underrunSticky", int'(o_underrun), 1);
    checkOutput("underrunNoPop", int'(o_data), romFn(12));
    applyStimulus(1'b0, 1'b0, 3'd1, 3'd1);
    applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
    checkOutput("underrunCleared", int'(o_underrun), 0);

    // hs=2, vs=2 read order and frame wrap
    applyStimulus(1'b0, 1'b0, 3'd2, 3'd2);
    addrSeq.delete();
    doneAt = -1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, 3'd2, 3'd2);
      if (o_rom_ce) begin
        addrSeq.push_back(int'(o_rom_addr));
        if (o_frame_done && doneAt < 0) doneAt = addrSeq.size();
      end
    end
    checkOutput("seqLength", int'(addrSeq.size() >= 17), 1);
    for (int i = 0; i < 17; i++) begin
      if (i < addrSeq.size()) checkOutput($sformatf("seqAddr%0d", i), addrSeq[i], expAddr[i]);
    end
    checkOutput("frameDoneIndex", doneAt, 16);

    // hs=5, vs=0; hscale changed mid-frame must be ignored
    applyStimulus(1'b0, 1'b0, 3'd5, 3'd0);
    applyStimulus(1'b0, 1'b0, 3'd5, 3'd0);
    waitOk = 1'b0;
    for (int i = 0; i < 10 && !waitOk; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd5, 3'd0);
      waitOk = o_valid;
    end
    checkOutput("scaleWaitValid", int'(waitOk), 1);
    dataSeq.delete();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, 3'd1, 3'd0);
      dataSeq.push_back(o_valid ? int'(o_data) : -1);
    end
    run12 = 0; k = 0;
    while (k < dataSeq.size() && dataSeq[k] == romFn(12)) begin run12++; k++; end
    run13 = 0;
    while (k < dataSeq.size() && dataSeq[k] == romFn(13)) begin run13++; k++; end
    checkOutput("repeatPix12", run12, 5);
    checkOutput("repeatPix13", run13, 5);

    // Consumer stalled: credit limits reads to the FIFO depth
    applyStimulus(1'b0, 1'b0, 3'd1, 3'd1);
    applyStimulus(1'b0, 1'b0, 3'd1, 3'd1);
    ceCount = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
      if (o_rom_ce) ceCount++;
    end
    checkOutput("stallIssued", ceCount, 256);
    checkOutput("stallCe", int'(o_rom_ce), 0);
    checkOutput("stallValid", int'(o_valid), 1);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1, 3'd1, 3'd1);

    // Restart mid-row with reads in flight
    applyStimulus(1'b0, 1'b1, 3'd1, 3'd1);
    applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
    checkOutput("restartValid", int'(o_valid), 0);
    checkOutput("restartCe", int'(o_rom_ce), 0);
    applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
    checkOutput("restartCe1", int'(o_rom_ce), 1);
    checkOutput("restartAddr", int'(o_rom_addr), 12);
    waitOk = 1'b0;
    for (int i = 0; i < 10 && !waitOk; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd1, 3'd1);
      waitOk = o_valid;
    end
    checkOutput("restartWaitValid", int'(waitOk), 1);
    checkOutput("restartData", int'(o_data), romFn(12));

    // Randomized traffic, scales and restarts
    curH = 3'd1; curV = 3'd1; pNext = 50;
    for (int i = 0; i < 15000; i++) begin
      if (i % 1500 == 0) pNext = $urandom_range(5, 100);
      if ($urandom_range(0, 599) == 0) begin
        curH = SCALE_W'($urandom_range(0, 7));
        curV = SCALE_W'($urandom_range(0, 7));
        repeat ($urandom_range(1, 3))
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), curH, curV);
      end else begin
        if ($urandom_range(0, 199) == 0) curH = SCALE_W'($urandom_range(0, 7));
        if ($urandom_range(0, 199) == 0) curV = SCALE_W'($urandom_range(0, 7));
        applyStimulus(1'b1, 1'($urandom_range(0, 99) < pNext), curH, curV);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
